// File: rtl/npu_pkg.sv
// npu_pkg
//   Shared types and constants for the NPU PE-array sequencer.
//   Contents:
//     pe_ctrl_state_e  sequencer state encoding
//     PE_RD_LAT_MAX    largest supported buffer read latency
//     PE_CTRL_LEN_W    default width of the activation-vector count
//     max_int          elaboration-time helper for sizing counters
package npu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    CLEAR,
    STREAM,
    DRAIN,
    DONE
  } pe_ctrl_state_e;

  localparam int PE_RD_LAT_MAX = 4;
  localparam int PE_CTRL_LEN_W = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pe_ctrl_delay.sv
// pe_ctrl_delay
//   Fixed-latency shift pipe used to line control strobes up with data that
//   returns from the weight/activation buffers LAT cycles after the read.
//   Ports:
//     clk    in   1      clock
//     rst    in   1      synchronous reset, active-high
//     hold   in   1      freeze every stage (buffer output is frozen too)
//     flush  in   1      clear every stage; wins over hold
//     din    in   WIDTH  value entering the pipe this cycle
//     dout   out  WIDTH  value that entered LAT cycles ago (unstalled)
module pe_ctrl_delay
  import npu_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  // Out-of-range latencies are clamped so the pipe always has 1..MAX stages.
  localparam int DEPTH = (LAT < 1) ? 1 : ((LAT > PE_RD_LAT_MAX) ? PE_RD_LAT_MAX : LAT);

  logic [WIDTH-1:0] pipe [DEPTH];

  // Flush has priority over hold so an abort during a stall still empties the pipe.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      for (int s = 0; s < DEPTH; s++) pipe[s] <= '0;
    end else if (!hold) begin
      pipe[0] <= din;
      for (int s = 1; s < DEPTH; s++) pipe[s] <= pipe[s-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl
//   Sequencer for the ROWSxCOLS systolic PE array: loads one weight row per
//   cycle, clears the accumulators, streams K activation vectors, drains the
//   array skew and pulses done.
//   Ports:
//     clk, rst                    clock, synchronous active-high reset
//     start, abort                job request (IDLE only) / job cancel
//     cfg_w_base, cfg_a_base      weight / activation buffer base addresses
//     cfg_k_len                   number of activation vectors K (>=1)
//     stall                       activation buffer not ready; freezes STREAM/DRAIN
//     busy, done, cfg_err         job status
//     wbuf_rd_en, wbuf_rd_addr    weight buffer read port
//     abuf_rd_en, abuf_rd_addr    activation buffer read port
//     abuf_zero                   zero activations into the array while draining
//     pe_load_weight              one-hot row load select, aligned to returned weights
//     pe_enable, pe_clear_acc     PE array control
module pe_array_ctrl
  import npu_pkg::*;
#(
  parameter int ROWS   = 16,
  parameter int COLS   = 16,
  parameter int ADDR_W = 12,
  parameter int LEN_W  = PE_CTRL_LEN_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_a_base,
  input  logic [LEN_W-1:0]  cfg_k_len,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              cfg_err,
  output logic              wbuf_rd_en,
  output logic [ADDR_W-1:0] wbuf_rd_addr,
  output logic              abuf_rd_en,
  output logic [ADDR_W-1:0] abuf_rd_addr,
  output logic              abuf_zero,
  output logic [ROWS-1:0]   pe_load_weight,
  output logic              pe_enable,
  output logic              pe_clear_acc
);

  localparam int LOAD_LEN  = ROWS + RD_LAT;
  localparam int DRAIN_LEN = ROWS + COLS - 1 + RD_LAT;
  // One counter serves every phase, so it must cover both K and the fixed phase lengths.
  localparam int CNT_W = max_int(LEN_W, $clog2(max_int(LOAD_LEN, DRAIN_LEN)) + 1);

  pe_ctrl_state_e    state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] w_base, a_base;
  logic [LEN_W-1:0]  k_len;
  logic              cfg_err_q;

  logic              start_ok, frozen;
  logic              w_rd, a_rd;
  logic [ROWS-1:0]   lw_in, lw_out;
  logic              en_out;

  // abort in the same cycle as start means the start never happened.
  assign start_ok = (state == IDLE) && start && !abort;
  assign frozen   = stall && ((state == STREAM) || (state == DRAIN));
  assign w_rd     = (state == LOAD_W) && (cnt < CNT_W'(ROWS));
  assign a_rd     = (state == STREAM) && !stall;
  assign lw_in    = w_rd ? (ROWS'(1) << cnt) : '0;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok && (cfg_k_len != '0)) state_next = LOAD_W;
      LOAD_W:  if (cnt == CNT_W'(LOAD_LEN - 1)) state_next = CLEAR;
      CLEAR:   state_next = STREAM;
      STREAM:  if (!stall && (cnt == CNT_W'(k_len) - CNT_W'(1))) state_next = DRAIN;
      DRAIN:   if (!stall && (cnt == CNT_W'(DRAIN_LEN - 1))) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) state_next = IDLE;
  end

  // Phase counter restarts on every state change and holds while stalled;
  // the job configuration is captured once so later cfg changes cannot disturb a running job.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      w_base    <= '0;
      a_base    <= '0;
      k_len     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= start_ok && (cfg_k_len == '0);
      if (start_ok && (cfg_k_len != '0)) begin
        w_base <= cfg_w_base;
        a_base <= cfg_a_base;
        k_len  <= cfg_k_len;
      end
      if (state_next != state) begin
        cnt <= '0;
      end else if (!frozen && ((state == LOAD_W) || (state == STREAM) || (state == DRAIN))) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  pe_ctrl_delay #(.WIDTH(ROWS), .LAT(RD_LAT)) u_lw_delay (
    .clk   (clk),
    .rst   (rst),
    .hold  (1'b0),
    .flush (abort),
    .din   (lw_in),
    .dout  (lw_out)
  );

  pe_ctrl_delay #(.WIDTH(1), .LAT(RD_LAT)) u_en_delay (
    .clk   (clk),
    .rst   (rst),
    .hold  (frozen),
    .flush (abort),
    .din   (a_rd),
    .dout  (en_out)
  );

  // Addresses are forced to zero when the strobe is low so idle ports are quiet.
  always_comb begin
    busy           = (state == LOAD_W) || (state == CLEAR) || (state == STREAM) || (state == DRAIN);
    done           = (state == DONE);
    cfg_err        = cfg_err_q;
    wbuf_rd_en     = w_rd;
    wbuf_rd_addr   = w_rd ? (w_base + ADDR_W'(cnt)) : '0;
    abuf_rd_en     = a_rd;
    abuf_rd_addr   = a_rd ? (a_base + ADDR_W'(cnt)) : '0;
    abuf_zero      = (state == DRAIN);
    pe_load_weight = (state == LOAD_W) ? lw_out : '0;
    pe_clear_acc   = (state == CLEAR);
    pe_enable      = 1'b0;
    if (state == STREAM)     pe_enable = en_out && !stall;
    else if (state == DRAIN) pe_enable = !stall;
  end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl
//   Directed bench for pe_array_ctrl with ROWS=COLS=4. A RD_LAT=1 instance is
//   driven from a per-cycle vector table plus hand-written stall/abort/reset
//   sequences; a second RD_LAT=3 instance checks the enable alignment.
//   Expected job length (no stall): 2*RD_LAT + 2*ROWS + COLS + K + 1 cycles.
module tb_pe_array_ctrl;

  logic        clk;
  logic        rst;
  logic        start, abort, stall, start3;
  logic [11:0] cfg_w_base, cfg_a_base;
  logic [15:0] cfg_k_len;

  logic        busy, done, cfg_err, wbuf_rd_en, abuf_rd_en, abuf_zero, pe_enable, pe_clear_acc;
  logic [11:0] wbuf_rd_addr, abuf_rd_addr;
  logic [3:0]  pe_load_weight;

  logic        busy3, done3, cfg_err3, wbuf_rd_en3, abuf_rd_en3, abuf_zero3, pe_enable3, pe_clear_acc3;
  logic [11:0] wbuf_rd_addr3, abuf_rd_addr3;
  logic [3:0]  pe_load_weight3;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        cfg_err;
    logic        wen;
    logic [11:0] waddr;
    logic        aen;
    logic [11:0] aaddr;
    logic        zero;
    logic [3:0]  lw;
    logic        en;
    logic        clr;
  } out_t;

  typedef struct {
    logic start;
    logic abort;
    logic stall;
    out_t exp;
  } vec_t;

  vec_t        tbl [20];
  int          vectors_applied;
  int          miscompares;
  logic [11:0] a_log [$];
  logic [11:0] w_log [$];
  logic [63:0] a_sig, w_sig, abort_out;
  int          stall_bad;
  int          done_at;
  int          first_aen, first_en, en_during_aen, done3_at;

  pe_array_ctrl #(.ROWS(4), .COLS(4), .ADDR_W(12), .LEN_W(16), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .cfg_w_base(cfg_w_base), .cfg_a_base(cfg_a_base), .cfg_k_len(cfg_k_len), .stall(stall),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .wbuf_rd_en(wbuf_rd_en), .wbuf_rd_addr(wbuf_rd_addr),
    .abuf_rd_en(abuf_rd_en), .abuf_rd_addr(abuf_rd_addr), .abuf_zero(abuf_zero),
    .pe_load_weight(pe_load_weight), .pe_enable(pe_enable), .pe_clear_acc(pe_clear_acc)
  );

  pe_array_ctrl #(.ROWS(4), .COLS(4), .ADDR_W(12), .LEN_W(16), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .abort(1'b0),
    .cfg_w_base(cfg_w_base), .cfg_a_base(cfg_a_base), .cfg_k_len(cfg_k_len), .stall(1'b0),
    .busy(busy3), .done(done3), .cfg_err(cfg_err3),
    .wbuf_rd_en(wbuf_rd_en3), .wbuf_rd_addr(wbuf_rd_addr3),
    .abuf_rd_en(abuf_rd_en3), .abuf_rd_addr(abuf_rd_addr3), .abuf_zero(abuf_zero3),
    .pe_load_weight(pe_load_weight3), .pe_enable(pe_enable3), .pe_clear_acc(pe_clear_acc3)
  );

  // Free-running 10-unit clock; inputs change on the falling edge.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t mk_out(input bit b, input bit d, input bit we, input int wa,
                                  input bit ae, input int aa, input bit z, input int lw,
                                  input bit en, input bit cl);
    out_t o;
    o.busy    = b;
    o.done    = d;
    o.cfg_err = 1'b0;
    o.wen     = we;
    o.waddr   = 12'(wa);
    o.aen     = ae;
    o.aaddr   = 12'(aa);
    o.zero    = z;
    o.lw      = 4'(lw);
    o.en      = en;
    o.clr     = cl;
    return o;
  endfunction

  function automatic out_t get_out();
    return {busy, done, cfg_err, wbuf_rd_en, wbuf_rd_addr, abuf_rd_en, abuf_rd_addr,
            abuf_zero, pe_load_weight, pe_enable, pe_clear_acc};
  endfunction

  function automatic out_t get_out3();
    return {busy3, done3, cfg_err3, wbuf_rd_en3, wbuf_rd_addr3, abuf_rd_en3, abuf_rd_addr3,
            abuf_zero3, pe_load_weight3, pe_enable3, pe_clear_acc3};
  endfunction

  // Address-log signature: count in the top 16 bits, first four addresses below.
  function automatic logic [63:0] exp_sig(input int n, input int e0, input int e1,
                                          input int e2, input int e3);
    return {16'(n), 12'(e3), 12'(e2), 12'(e1), 12'(e0)};
  endfunction

  // Drives one cycle of inputs on the falling edge, then lets outputs settle.
  task automatic applyStimulus(input logic s, input logic a, input logic st);
    @(negedge clk);
    start = s;
    abort = a;
    stall = st;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vectors_applied++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Runs one job on the RD_LAT=1 instance, logging every issued address and
  // the cycle done is first seen (cycle 0 is the cycle start is driven).
  task automatic runJob(input logic [63:0] start_mask, input logic [63:0] stall_mask,
                        input int abort_at, input int max_cyc);
    a_log.delete();
    w_log.delete();
    stall_bad = 0;
    done_at   = -1;
    abort_out = '1;
    for (int c = 0; c < max_cyc; c++) begin
      applyStimulus(start_mask[c], c == abort_at, stall_mask[c]);
      if (abuf_rd_en) a_log.push_back(abuf_rd_addr);
      if (wbuf_rd_en) w_log.push_back(wbuf_rd_addr);
      if (stall && busy && (abuf_rd_en || pe_enable)) stall_bad++;
      if (c == abort_at + 1) abort_out = 64'(get_out());
      if (done && done_at < 0) done_at = c;
      if (done_at >= 0 && c > done_at) break;
    end
    a_sig = {16'(a_log.size()), 48'(0)};
    w_sig = {16'(w_log.size()), 48'(0)};
    for (int i = 0; i < 4; i++) begin
      if (i < a_log.size()) a_sig[i*12 +: 12] = a_log[i];
      if (i < w_log.size()) w_sig[i*12 +: 12] = w_log[i];
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic runTable(input string tag);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i].start, tbl[i].abort, tbl[i].stall);
      checkOutput($sformatf("%s_c%0d", tag, i), 64'(get_out()), 64'(tbl[i].exp));
    end
  endtask

  // Main sequence: reset, reference job table, then the multi-cycle corner cases.
  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    rst        = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    stall      = 1'b0;
    start3     = 1'b0;
    cfg_k_len  = 16'd3;
    cfg_w_base = 12'h010;
    cfg_a_base = 12'h020;

    // Reference job K=3, w_base=0x10, a_base=0x20: LOAD_W c1..c5, CLEAR c6,
    // STREAM c7..c9, DRAIN c10..c17, DONE c18.
    for (int i = 0; i < 20; i++) begin
      tbl[i].start = (i == 0);
      tbl[i].abort = 1'b0;
      tbl[i].stall = 1'b0;
      tbl[i].exp   = mk_out(1, 0, 0, 0, 0, 0, 1, 0, 1, 0);
    end
    tbl[0].exp  = mk_out(0, 0, 0, 0,     0, 0,     0, 0, 0, 0);
    tbl[1].exp  = mk_out(1, 0, 1, 'h10,  0, 0,     0, 0, 0, 0);
    tbl[2].exp  = mk_out(1, 0, 1, 'h11,  0, 0,     0, 1, 0, 0);
    tbl[3].exp  = mk_out(1, 0, 1, 'h12,  0, 0,     0, 2, 0, 0);
    tbl[4].exp  = mk_out(1, 0, 1, 'h13,  0, 0,     0, 4, 0, 0);
    tbl[5].exp  = mk_out(1, 0, 0, 0,     0, 0,     0, 8, 0, 0);
    tbl[6].exp  = mk_out(1, 0, 0, 0,     0, 0,     0, 0, 0, 1);
    tbl[7].exp  = mk_out(1, 0, 0, 0,     1, 'h20,  0, 0, 0, 0);
    tbl[8].exp  = mk_out(1, 0, 0, 0,     1, 'h21,  0, 0, 1, 0);
    tbl[9].exp  = mk_out(1, 0, 0, 0,     1, 'h22,  0, 0, 1, 0);
    tbl[18].exp = mk_out(0, 1, 0, 0,     0, 0,     0, 0, 0, 0);
    tbl[19].exp = mk_out(0, 0, 0, 0,     0, 0,     0, 0, 0, 0);

    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_state", 64'(get_out()), 64'(0));
    checkOutput("reset_state_lat3", 64'(get_out3()), 64'(0));
    rst = 1'b0;

    runTable("job");

    // Stall two cycles at j=1 and one cycle in DRAIN: done moves from 18 to 21.
    runJob(64'h1, 64'h4300, -1, 60);
    checkOutput("stall_done_cycle", 64'(done_at), 64'(21));
    checkOutput("stall_abuf_seq", a_sig, exp_sig(3, 'h20, 'h21, 'h22, 0));
    checkOutput("stall_wbuf_seq", w_sig, exp_sig(4, 'h10, 'h11, 'h12, 'h13));
    checkOutput("stall_quiet", 64'(stall_bad), 64'(0));

    // Abort during STREAM at j=1 (cycle 8): IDLE and quiet next cycle, no done.
    runJob(64'h1, 64'h0, 8, 30);
    checkOutput("abort_outputs", abort_out, 64'(0));
    checkOutput("abort_no_done", 64'(done_at), 64'(-1));
    checkOutput("abort_abuf_seq", a_sig, exp_sig(2, 'h20, 'h21, 0, 0));
    runTable("after_abort");

    // K=0 start: one-cycle cfg_err, busy never rises.
    cfg_k_len = 16'd0;
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("kzero_c0", 64'(get_out()), 64'(0));
    applyStimulus(1'b0, 1'b0, 1'b0);
    begin
      out_t e;
      e = mk_out(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      e.cfg_err = 1'b1;
      checkOutput("kzero_c1", 64'(get_out()), 64'(e));
    end
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("kzero_c2", 64'(get_out()), 64'(0));
    cfg_k_len = 16'd3;

    // Extra start pulses while busy must change nothing.
    runJob(64'h8109, 64'h0, -1, 60);
    checkOutput("restart_done_cycle", 64'(done_at), 64'(18));
    checkOutput("restart_abuf_seq", a_sig, exp_sig(3, 'h20, 'h21, 'h22, 0));
    checkOutput("restart_wbuf_seq", w_sig, exp_sig(4, 'h10, 'h11, 'h12, 'h13));

    // Activation address wraps past 0xFFF; one more vector adds one cycle.
    cfg_k_len  = 16'd4;
    cfg_a_base = 12'hFFE;
    runJob(64'h1, 64'h0, -1, 60);
    checkOutput("wrap_abuf_seq", a_sig, exp_sig(4, 'hFFE, 'hFFF, 'h000, 'h001));
    checkOutput("wrap_done_cycle", 64'(done_at), 64'(19));
    cfg_k_len  = 16'd3;
    cfg_a_base = 12'h020;

    // Synchronous reset in LOAD_W: quiet the next cycle, then a clean job.
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_loadw_c1", 64'(get_out()), 64'(tbl[1].exp));
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_loadw_c3", 64'(get_out()), 64'(0));
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("rst_loadw_c4", 64'(get_out()), 64'(0));
    runJob(64'h1, 64'h0, -1, 60);
    checkOutput("after_rst_done_cycle", 64'(done_at), 64'(18));

    // RD_LAT=3 instance: STREAM c9..c11, first pe_enable at c12, done at c22.
    first_aen     = -1;
    first_en      = -1;
    en_during_aen = 0;
    done3_at      = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      start3 = (c == 0);
      #1;
      if (abuf_rd_en3 && first_aen < 0) first_aen = c;
      if (pe_enable3 && first_en < 0) first_en = c;
      if (abuf_rd_en3 && pe_enable3) en_during_aen++;
      if (done3 && done3_at < 0) done3_at = c;
    end
    checkOutput("lat3_first_aen", 64'(first_aen), 64'(9));
    checkOutput("lat3_first_en", 64'(first_en), 64'(12));
    checkOutput("lat3_en_in_stream", 64'(en_during_aen), 64'(0));
    checkOutput("lat3_done_cycle", 64'(done3_at), 64'(22));

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
